nukv_ht_match: RTL and testbench

- Downstream neighbour of the hash-table read stage.
- Buffers key tuples leaving the read stage and pairs each one, in order, with the bucket word the memory returns for its read command.
- Compares the tuple key against every slot of the bucket, then emits tuple + bucket + hit/free-slot results to the update/write stage.
- Tuples flagged "no read issued" pass through without consuming a memory word.

---
 rtl/nukv_ht_match_pkg.sv | 30 +++
 rtl/nukv_ht_match_fifo_tuple.sv | 50 +++++
 rtl/nukv_ht_match.sv | 126 ++++++++++++
 tb/tb_nukv_ht_match.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nukv_ht_match_pkg.sv
// Shared nukv definitions: default geometry, tuple field offsets and slot index sizing.
package nukv_ht_match_pkg;

    localparam int KEY_WIDTH_DEF      = 128;
    localparam int META_WIDTH_DEF     = 96;
    localparam int HASHADDR_WIDTH_DEF = 32;
    localparam int MEMDATA_WIDTH_DEF  = 512;
    localparam int NUM_SLOTS_DEF      = 4;
    localparam int KEYQ_DEPTH_DEF     = 16;

    localparam int KEY_LSB = 0;

    // Tuple layout: {hash address, metadata, key}; skip flag lives inside the metadata.
    function automatic int skip_bit(input int key_w, input int meta_w);
        return key_w + meta_w - 4;
    endfunction

    function automatic int addr_lsb(input int key_w, input int meta_w);
        return key_w + meta_w;
    endfunction

    function automatic int addr_msb(input int key_w, input int meta_w, input int addr_w);
        return key_w + meta_w + addr_w - 1;
    endfunction

    function automatic int slot_idx_w(input int num_slots);
        return (num_slots > 1) ? $clog2(num_slots) : 1;
    endfunction

endpackage

// File: rtl/nukv_ht_match_fifo_tuple.sv
// Synchronous tuple FIFO with valid/ready on both sides; DEPTH must be a power of two.
module nukv_fifo_tuple #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    // Full blocks the write even when a pop happens in the same cycle.
    assign in_ready  = !rst && (count < FULL);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/nukv_ht_match.sv
// Hash-table match stage: pairs queued key tuples with returned bucket words in order,
// compares the key against every slot and reports hit / free-slot results downstream.
module nukv_ht_match
    import nukv_ht_match_pkg::*;
#(
    parameter int KEY_WIDTH      = KEY_WIDTH_DEF,
    parameter int META_WIDTH     = META_WIDTH_DEF,
    parameter int HASHADDR_WIDTH = HASHADDR_WIDTH_DEF,
    parameter int MEMDATA_WIDTH  = MEMDATA_WIDTH_DEF,
    parameter int NUM_SLOTS      = NUM_SLOTS_DEF,
    parameter int KEYQ_DEPTH     = KEYQ_DEPTH_DEF,
    localparam int TUPLE_W       = KEY_WIDTH + META_WIDTH + HASHADDR_WIDTH,
    localparam int SLOT_W        = slot_idx_w(NUM_SLOTS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TUPLE_W-1:0]       input_data,
    input  logic                     input_valid,
    output logic                     input_ready,
    input  logic [MEMDATA_WIDTH-1:0] rddata_data,
    input  logic                     rddata_valid,
    output logic                     rddata_ready,
    output logic [TUPLE_W-1:0]       output_data,
    output logic [MEMDATA_WIDTH-1:0] output_bucket,
    output logic                     output_hit,
    output logic [SLOT_W-1:0]        output_hit_slot,
    output logic                     output_free_valid,
    output logic [SLOT_W-1:0]        output_free_slot,
    output logic                     output_valid,
    input  logic                     output_ready,
    output logic [31:0]              stat_hits,
    output logic [31:0]              stat_misses
);

    localparam int SKIP_BIT = skip_bit(KEY_WIDTH, META_WIDTH);

    logic [TUPLE_W-1:0]   head;
    logic                 head_valid;
    logic                 head_skip;
    logic [KEY_WIDTH-1:0] head_key;
    logic                 out_free;
    logic                 fire;

    logic [KEY_WIDTH-1:0] slot;
    logic                 match_any;
    logic [SLOT_W-1:0]    match_idx;
    logic                 empty_any;
    logic [SLOT_W-1:0]    empty_idx;
    logic                 hit;
    logic                 free_valid;

    nukv_fifo_tuple #(
        .WIDTH (TUPLE_W),
        .DEPTH (KEYQ_DEPTH)
    ) u_keyq (
        .clk       (clk),
        .rst       (rst),
        .in_data   (input_data),
        .in_valid  (input_valid),
        .in_ready  (input_ready),
        .out_data  (head),
        .out_valid (head_valid),
        .out_ready (fire)
    );

    assign head_skip = head[SKIP_BIT];
    assign head_key  = head[KEY_LSB +: KEY_WIDTH];

    // Handshakes: a transfer happens on a cycle where valid && ready; valid never waits
    // on ready, and a held output keeps all its fields stable until output_ready.
    assign out_free     = !output_valid || output_ready;
    assign fire         = head_valid && out_free && (head_skip || rddata_valid);
    assign rddata_ready = head_valid && !head_skip && out_free;

    // Descending scan so the lowest matching / empty slot is the last one written.
    always_comb begin
        slot      = '0;
        match_any = 1'b0;
        match_idx = '0;
        empty_any = 1'b0;
        empty_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            slot = rddata_data[i*KEY_WIDTH +: KEY_WIDTH];
            if ((slot == head_key) && (head_key != '0)) begin
                match_any = 1'b1;
                match_idx = SLOT_W'(i);
            end
            if (slot == '0) begin
                empty_any = 1'b1;
                empty_idx = SLOT_W'(i);
            end
        end
    end

    assign hit        = match_any && !head_skip;
    assign free_valid = empty_any && !head_skip;

    always_ff @(posedge clk) begin
        if (rst) begin
            output_valid      <= 1'b0;
            output_data       <= '0;
            output_bucket     <= '0;
            output_hit        <= 1'b0;
            output_hit_slot   <= '0;
            output_free_valid <= 1'b0;
            output_free_slot  <= '0;
            stat_hits         <= '0;
            stat_misses       <= '0;
        end else begin
            if (fire) begin
                output_valid      <= 1'b1;
                output_data       <= head;
                output_bucket     <= head_skip ? '0 : rddata_data;
                output_hit        <= hit;
                output_hit_slot   <= hit ? match_idx : '0;
                output_free_valid <= free_valid;
                output_free_slot  <= free_valid ? empty_idx : '0;
                stat_hits         <= stat_hits + 32'(hit);
                stat_misses       <= stat_misses + 32'(!hit && !head_skip);
            end else if (output_ready) begin
                output_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nukv_ht_match.sv
// Directed bench for nukv_ht_match: tuples and bucket words are driven, expected
// results are queued from a reference model and compared as the DUT emits them.
module tb_nukv_ht_match;

    localparam int KW   = 128;
    localparam int MW   = 96;
    localparam int HW   = 32;
    localparam int DW   = 512;
    localparam int NS   = 4;
    localparam int TW   = KW + MW + HW;
    localparam int SW   = 2;
    localparam int SKIP = KW + MW - 4;
    localparam int RW   = TW + DW + 1 + SW + 1 + SW;
    localparam int HIT_BIT = 2 * SW + 1;

    logic          clk;
    logic          rst;
    logic [TW-1:0] input_data;
    logic          input_valid;
    logic          input_ready;
    logic [DW-1:0] rddata_data;
    logic          rddata_valid;
    logic          rddata_ready;
    logic [TW-1:0] output_data;
    logic [DW-1:0] output_bucket;
    logic          output_hit;
    logic [SW-1:0] output_hit_slot;
    logic          output_free_valid;
    logic [SW-1:0] output_free_slot;
    logic          output_valid;
    logic          output_ready;
    logic [31:0]   stat_hits;
    logic [31:0]   stat_misses;

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] got_q[$];
    logic [TW-1:0] bp[17];

    nukv_ht_match #(
        .KEY_WIDTH      (KW),
        .META_WIDTH     (MW),
        .HASHADDR_WIDTH (HW),
        .MEMDATA_WIDTH  (DW),
        .NUM_SLOTS      (NS),
        .KEYQ_DEPTH     (16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .input_data        (input_data),
        .input_valid       (input_valid),
        .input_ready       (input_ready),
        .rddata_data       (rddata_data),
        .rddata_valid      (rddata_valid),
        .rddata_ready      (rddata_ready),
        .output_data       (output_data),
        .output_bucket     (output_bucket),
        .output_hit        (output_hit),
        .output_hit_slot   (output_hit_slot),
        .output_free_valid (output_free_valid),
        .output_free_slot  (output_free_slot),
        .output_valid      (output_valid),
        .output_ready      (output_ready),
        .stat_hits         (stat_hits),
        .stat_misses       (stat_misses)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Output monitor: one entry per accepted result
    always @(negedge clk) begin
        if (!rst && output_valid && output_ready)
            got_q.push_back({output_data, output_bucket, output_hit, output_hit_slot,
                             output_free_valid, output_free_slot});
    end

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [RW-1:0] model(input logic [TW-1:0] t, input logic [DW-1:0] w);
        logic [KW-1:0] k;
        logic [KW-1:0] s;
        logic h;
        logic f;
        logic [SW-1:0] hs;
        logic [SW-1:0] fs;
        k = t[KW-1:0];
        h = 1'b0;
        f = 1'b0;
        hs = '0;
        fs = '0;
        if (t[SKIP]) return {t, {DW{1'b0}}, 1'b0, {SW{1'b0}}, 1'b0, {SW{1'b0}}};
        for (int i = 0; i < NS; i++) begin
            s = w[i*KW +: KW];
            if (!h && k != '0 && s == k) begin h = 1'b1; hs = SW'(i); end
            if (!f && s == '0) begin f = 1'b1; fs = SW'(i); end
        end
        return {t, w, h, hs, f, fs};
    endfunction

    function automatic logic [TW-1:0] mk_tuple(input logic [KW-1:0] key, input logic skip);
        logic [TW-1:0] t;
        for (int i = 0; i < TW / 32; i++) t[i*32 +: 32] = $urandom;
        t[KW-1:0] = key;
        t[SKIP] = skip;
        return t;
    endfunction

    task automatic expect_result(input logic [TW-1:0] t, input logic [DW-1:0] w);
        logic [RW-1:0] r;
        r = model(t, w);
        exp_q.push_back(r);
        if (r[HIT_BIT]) exp_hits++;
        else if (!t[SKIP]) exp_misses++;
    endtask

    // Driver tasks: start and end at posedge+1
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [TW-1:0] t);
        logic ok;
        int n;
        n = 0;
        input_data = t;
        input_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = input_ready;
            sync();
            n++;
        end while (!ok && n < 100);
        input_valid = 1'b0;
        check("push_timeout", ok, 1'b1);
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        logic ok;
        int n;
        n = 0;
        rddata_data = w;
        rddata_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = rddata_ready;
            sync();
            n++;
        end while (!ok && n < 100);
        rddata_valid = 1'b0;
        check("word_timeout", ok, 1'b1);
    endtask

    // Scoreboard: wait for n results and compare against the expected queue; ends on a negedge
    task automatic compare_results(input int n, input string tag);
        int k;
        k = 0;
        while (got_q.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (got_q.size() > 0 && exp_q.size() > 0)
                check(tag, got_q.pop_front(), exp_q.pop_front());
        end
    endtask

    initial begin
        logic [TW-1:0] t;
        logic [TW-1:0] t2;
        logic [DW-1:0] w;
        logic [KW-1:0] key;

        rst = 1'b1;
        input_data = '0;
        input_valid = 1'b0;
        rddata_data = '0;
        rddata_valid = 1'b0;
        output_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_input_ready", input_ready, 1'b0);
        check("rst_output_valid", output_valid, 1'b0);
        check("rst_stat_hits", stat_hits, 32'd0);
        check("rst_stat_misses", stat_misses, 32'd0);
        check("rst_output_data", output_data, '0);
        check("rst_output_flags", {output_hit, output_hit_slot, output_free_valid, output_free_slot}, '0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", input_ready, 1'b1);
        sync();

        // Hit in slot 2 with slot 0 empty
        t = mk_tuple(128'hA5, 1'b0);
        w = {128'h22, 128'hA5, 128'h11, 128'h0};
        expect_result(t, w);
        push(t);
        send_word(w);
        compare_results(1, "hit");
        check("hit_stat_hits", stat_hits, 32'(exp_hits));
        sync();

        // Miss in a full bucket
        t = mk_tuple(128'h7, 1'b0);
        w = {128'd4, 128'd3, 128'd2, 128'd1};
        expect_result(t, w);
        push(t);
        send_word(w);
        compare_results(1, "miss_full");
        check("miss_stat_misses", stat_misses, 32'(exp_misses));
        sync();

        // Skip tuple passes through while an unrelated word waits for the next real tuple
        w = {128'h44, 128'h55, 128'h66, 128'h77};
        rddata_data = w;
        rddata_valid = 1'b1;
        t = mk_tuple(128'h99, 1'b1);
        t2 = mk_tuple(128'h66, 1'b0);
        expect_result(t, w);
        expect_result(t2, w);
        push(t);
        @(negedge clk);
        check("skip_rddata_ready", rddata_ready, 1'b0);
        sync();
        push(t2);
        send_word(w);
        compare_results(2, "skip");
        check("skip_stat_hits", stat_hits, 32'(exp_hits));
        sync();

        // Word arrives before any tuple
        w = {128'h0, 128'h3, 128'h2, 128'h1};
        rddata_data = w;
        rddata_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("early_word_rddata_ready", rddata_ready, 1'b0);
            sync();
        end
        t = mk_tuple(128'h5, 1'b0);
        expect_result(t, w);
        input_data = t;
        input_valid = 1'b1;
        @(negedge clk);
        check("early_word_input_ready", input_ready, 1'b1);
        sync();
        input_valid = 1'b0;
        @(negedge clk);
        check("early_word_fire", {rddata_ready, output_valid}, 2'b10);
        sync();
        rddata_valid = 1'b0;
        @(negedge clk);
        check("early_word_latency", output_valid, 1'b1);
        compare_results(1, "early_word");
        check("early_stat_misses", stat_misses, 32'(exp_misses));
        sync();

        // Randomised hit/miss/free patterns
        for (int n = 0; n < 6; n++) begin
            key = KW'($urandom_range(1, 255));
            for (int i = 0; i < NS; i++) begin
                case ($urandom_range(0, 2))
                    0: w[i*KW +: KW] = '0;
                    1: w[i*KW +: KW] = key;
                    default: w[i*KW +: KW] = key + KW'(i + 300);
                endcase
            end
            t = mk_tuple(key, 1'b0);
            expect_result(t, w);
            push(t);
            send_word(w);
        end
        compare_results(6, "random");
        check("random_stat_hits", stat_hits, 32'(exp_hits));
        check("random_stat_misses", stat_misses, 32'(exp_misses));
        sync();

        // Backpressure: one held result plus a full queue
        output_ready = 1'b0;
        rddata_data = '0;
        for (int i = 0; i < 17; i++) begin
            bp[i] = mk_tuple(KW'($urandom_range(1, 1000)), 1'b1);
            expect_result(bp[i], '0);
            push(bp[i]);
            if (i == 15) begin
                @(negedge clk);
                check("bp_ready_after_16", input_ready, 1'b1);
                sync();
            end
        end
        @(negedge clk);
        check("bp_ready_after_17", input_ready, 1'b0);
        check("bp_held_data", output_data, bp[0]);
        repeat (5) @(negedge clk);
        check("bp_hold_valid", output_valid, 1'b1);
        check("bp_hold_data", output_data, bp[0]);
        sync();
        output_ready = 1'b1;
        repeat (18) @(negedge clk);
        check("bp_drain_rate", got_q.size(), 17);
        check("bp_drained_valid", output_valid, 1'b0);
        compare_results(17, "bp");
        check("bp_stat_misses", stat_misses, 32'(exp_misses));
        sync();

        // Reset with work in flight
        output_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(mk_tuple(KW'(i + 1), 1'b1));
        @(negedge clk);
        check("pre_rst_valid", output_valid, 1'b1);
        sync();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_input_ready", input_ready, 1'b0);
        sync();
        rst = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        @(negedge clk);
        check("post_rst_valid", output_valid, 1'b0);
        check("post_rst_stats", {stat_hits, stat_misses}, 64'd0);
        check("post_rst_input_ready", input_ready, 1'b1);
        check("post_rst_output_data", output_data, '0);
        sync();
        output_ready = 1'b1;
        t = mk_tuple(128'h42, 1'b0);
        w = {128'h1, 128'h2, 128'h0, 128'h42};
        expect_result(t, w);
        push(t);
        send_word(w);
        compare_results(1, "post_rst");
        check("post_rst_stat_hits", stat_hits, 32'(exp_hits));
        check("exp_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
